i2s_frame_feeder: RTL
=====================

// Module: i2s_frame_feeder
// PURPOSE
//  Upstream stage of the I2S serializer. Buffers stereo sample pairs from the waveform generators in a small FIFO.
//  Derives I2S_SCLK and I2S_LRCLK from the system clock by division.
//  Presents one left-justified 32-bit word on `sample`, held stable for each 32-bit slot, for the serializer to shift out.
// PARAMETERS
//  SCLK_DIV    4   Clk cycles per SCLK half-period; >= 2. SCLK period = 2*SCLK_DIV Clk.
//  SAMPLE_W    24  width of each input channel sample (two's complement); 1..32
//  FIFO_DEPTH  8   stereo pairs buffered; power of 2, >= 2
// PORTS
//  Clk         in   1                      system clock; all state updates on posedge
//  Reset_n     in   1                      asynchronous, active-low reset
//  in_valid    in   1                      input pair valid
//  in_ready    out  1                      FIFO can accept a pair
//  in_left     in   SAMPLE_W               left-channel sample
//  in_right    in   SAMPLE_W               right-channel sample
//  mute        in   1                      force zero output; FIFO still drains
//  I2S_SCLK    out  1                      bit clock, registered
//  I2S_LRCLK   out  1                      word select; 0 = left slot, 1 = right slot
//  sample      out  32                     current slot word to the serializer
//  underrun    out  1                      1-Clk pulse: frame started with FIFO empty
//  fill_level  out  $clog2(FIFO_DEPTH)+1   pairs currently stored
// BEHAVIOUR
//  Reset (Reset_n low, asynchronous)
//  - I2S_SCLK=0, I2S_LRCLK=0, sample=0, underrun=0, fill_level=0.
//  - Divider and bit counter cleared; FIFO flushed; right-hold register cleared.
//  - Pushes ignored while in reset. Reset mid-frame aborts the frame immediately; no partial state is kept.
//  Clock divider
//  - div_cnt counts 0..SCLK_DIV-1 and wraps. At terminal count, I2S_SCLK toggles.
//  - First SCLK rise occurs SCLK_DIV Clk after reset release.
//  Bit counter
//  - bit_cnt (6 bits) increments on each Clk where SCLK toggles 1->0; wraps 63->0.
//  - I2S_LRCLK = bit_cnt[5], registered. It changes only coincident with an SCLK falling edge.
//  - Frame = 64 SCLK periods: slot L is bit_cnt 0..31, slot R is bit_cnt 32..63.
//  Slot-start events (Clk cycle of the SCLK falling edge)
//  - L-start (bit_cnt 63->0, plus the first fall after reset):
//    - FIFO non-empty: pop one pair. sample <= mute ? 0 : LJ(left). hold_r <= mute ? 0 : LJ(right).
//    - FIFO empty: sample <= 0, hold_r <= 0, underrun=1 for exactly this Clk.
//  - R-start (bit_cnt 31->32): sample <= hold_r.
//  - No other event changes `sample`. It is therefore stable for 32 full SCLK periods and settled before every SCLK rise.
//  - LJ(x) = {x, (32-SAMPLE_W)'b0}; for SAMPLE_W=32, LJ(x) = x.
//  FIFO
//  - in_ready = (fill_level != FIFO_DEPTH), combinational from registered fill.
//  - Push when in_valid && in_ready; data written at posedge.
//  - Push and pop in the same Clk: both take effect; fill_level unchanged.
//  - When full, in_ready=0 and in_valid is ignored; no overwrite.
//    A pop at full raises in_ready on the next Clk.
//  - Pointers wrap modulo FIFO_DEPTH. The extra fill bit distinguishes full from empty.
//  - Ordering is strict FIFO; left and right of one pair always leave in the same frame.
//  Latency
//  - A pair pushed into an empty FIFO at least 1 Clk before an L-start appears at that L-start.
//  - Otherwise it appears at the next L-start.
// TESTING (SCLK_DIV=2, SAMPLE_W=24, FIFO_DEPTH=4)
//  1. Hold Reset_n low 10 Clk -> all outputs 0, in_ready=1. Release -> SCLK rises at Clk 2, period 4 Clk; LRCLK period 256 Clk, 50% duty.
//  2. Push L=24'h123456, R=24'hABCDEF before first L-start -> sample=32'h12345600 while LRCLK=0, then 32'hABCDEF00 while LRCLK=1; fill 1->0 at L-start.
//  3. No pushes -> sample=0 in both slots; underrun pulses once per frame, 1 Clk wide, coincident with the L-start SCLK fall.
//  4. Push 5 pairs back-to-back -> in_ready=0 after 4th, 5th held off; at next L-start pop, in_ready=1 next Clk and the 5th is accepted; output order 1,2,3,4,5.
//  5. Fill 3 pairs, assert mute -> sample=0 for 3 frames, fill_level 3->2->1->0, no underrun until the 4th frame.
//  6. Assert Reset_n low mid R-slot with 2 pairs buffered -> SCLK, LRCLK, sample=0 same Clk (async); after release fill_level=0 and the first frame underruns.

Source files
------------

// File: rtl/i2s_frame_feeder.sv
// rtl/i2s_frame_feeder.sv - I2S frame feeder: stereo pair FIFO, SCLK/LRCLK divider, per-slot sample word
module i2s_frame_feeder #(
    parameter int SCLK_DIV   = 4,
    parameter int SAMPLE_W   = 24,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SAMPLE_W-1:0]         in_left,
    input  logic [SAMPLE_W-1:0]         in_right,
    input  logic                        mute,
    output logic                        I2S_SCLK,
    output logic                        I2S_LRCLK,
    output logic [31:0]                 sample,
    output logic                        underrun,
    output logic [$clog2(FIFO_DEPTH):0] fill_level
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int FW = PW + 1;
    localparam int DW = $clog2(SCLK_DIV);
    localparam logic [DW-1:0] DIV_LAST  = DW'(SCLK_DIV - 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(FIFO_DEPTH);

    logic [DW-1:0]       div_cnt_q, div_cnt_d;
    logic                sclk_q, sclk_d;
    logic                lrclk_q, lrclk_d;
    logic [5:0]          bit_cnt_q, bit_cnt_d;
    logic                started_q, started_d;
    logic [31:0]         sample_q, sample_d;
    logic [31:0]         hold_r_q, hold_r_d;
    logic                underrun_q, underrun_d;
    logic [FW-1:0]       fill_q, fill_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [SAMPLE_W-1:0] mem_l [FIFO_DEPTH];
    logic [SAMPLE_W-1:0] mem_r [FIFO_DEPTH];

    logic div_term, sclk_fall, l_start, r_start, fifo_empty, do_push, do_pop;

    function automatic logic [31:0] lj(input logic [SAMPLE_W-1:0] x);
        return 32'(x) << (32 - SAMPLE_W);
    endfunction

    assign in_ready = (fill_q != FILL_FULL);

    always_comb begin
        div_term   = (div_cnt_q == DIV_LAST);
        sclk_fall  = div_term && sclk_q;
        // The very first fall after reset opens the left slot without advancing bit_cnt,
        // so every frame, including the first, has two full 32-bit slots.
        l_start    = sclk_fall && (!started_q || bit_cnt_q == 6'd63);
        r_start    = sclk_fall && started_q && bit_cnt_q == 6'd31;
        fifo_empty = (fill_q == '0);
        do_push    = in_valid && in_ready;
        do_pop     = l_start && !fifo_empty;

        div_cnt_d  = div_term ? '0 : div_cnt_q + DW'(1);
        sclk_d     = div_term ? !sclk_q : sclk_q;
        started_d  = started_q || sclk_fall;
        bit_cnt_d  = (sclk_fall && started_q) ? bit_cnt_q + 6'd1 : bit_cnt_q;
        lrclk_d    = bit_cnt_d[5];

        sample_d   = sample_q;
        hold_r_d   = hold_r_q;
        underrun_d = l_start && fifo_empty;
        if (do_pop) begin
            sample_d = mute ? '0 : lj(mem_l[rd_ptr_q]);
            hold_r_d = mute ? '0 : lj(mem_r[rd_ptr_q]);
        end else if (l_start) begin
            sample_d = '0;
            hold_r_d = '0;
        end else if (r_start) begin
            sample_d = hold_r_q;
        end

        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        fill_d   = fill_q + FW'(do_push) - FW'(do_pop);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            bit_cnt_q  <= '0;
            started_q  <= 1'b0;
            sample_q   <= '0;
            hold_r_q   <= '0;
            underrun_q <= 1'b0;
            fill_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            sclk_q     <= sclk_d;
            lrclk_q    <= lrclk_d;
            bit_cnt_q  <= bit_cnt_d;
            started_q  <= started_d;
            sample_q   <= sample_d;
            hold_r_q   <= hold_r_d;
            underrun_q <= underrun_d;
            fill_q     <= fill_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage is not reset; the flushed pointers make stale entries unreachable.
    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem_l[wr_ptr_q] <= in_left;
            mem_r[wr_ptr_q] <= in_right;
        end
    end

    assign I2S_SCLK   = sclk_q;
    assign I2S_LRCLK  = lrclk_q;
    assign sample     = sample_q;
    assign underrun   = underrun_q;
    assign fill_level = fill_q;

endmodule
